// File: rtl/icache.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : icache
// Brief    : Direct-mapped read-only instruction cache, combinational hit path,
//            single-line refill over a request/grant + beat-valid interface.
//            Optional macro ICACHE_PERF_EN adds saturating hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module icache #(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_if,
    output logic [31:0] instr_if,
    output logic        stall_o,
    input  logic        flush_i,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] perf_hits_o,
    output logic [31:0] perf_misses_o
`endif
);

    localparam int c_OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int c_IDX_W   = $clog2(NUM_LINES);
    localparam int c_TAG_LSB = 2 + c_OFF_W + c_IDX_W;
    localparam int c_TAG_W   = 32 - c_TAG_LSB;
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2
    } state_t;

    state_t                     r_state;
    logic [NUM_LINES-1:0]       r_valid;
    logic [c_TAG_W-1:0]         r_tag  [NUM_LINES];
    logic [31:0]                r_data [NUM_LINES][WORDS_PER_LINE];
    logic [c_OFF_W-1:0]         r_cnt;
    logic                       r_flush_pend;
    logic                       r_mem_req;
    logic [31:0]                r_mem_addr;

    logic [c_OFF_W-1:0]         w_off;
    logic [c_IDX_W-1:0]         w_idx;
    logic [c_TAG_W-1:0]         w_tag;
    logic [c_IDX_W-1:0]         w_fill_idx;
    logic [c_TAG_W-1:0]         w_fill_tag;
    logic                       w_hit;
    logic                       w_miss;
    logic                       w_beat;
    logic                       w_last_beat;
    logic                       w_unused_lsbs;

    assign w_off         = pc_if[1+c_OFF_W:2];
    assign w_idx         = pc_if[c_TAG_LSB-1:2+c_OFF_W];
    assign w_tag         = pc_if[31:c_TAG_LSB];
    assign w_unused_lsbs = ^pc_if[1:0];

    // Refill indexing comes only from the latched line address.
    assign w_fill_idx = r_mem_addr[c_TAG_LSB-1:2+c_OFF_W];
    assign w_fill_tag = r_mem_addr[31:c_TAG_LSB];

    always_comb begin
        w_hit  = (r_state == S_IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
        w_miss = (r_state == S_IDLE) && !w_hit;
    end

    assign w_beat      = (r_state == S_FILL) && mem_rvalid;
    assign w_last_beat = w_beat && (r_cnt == c_OFF_W'(WORDS_PER_LINE - 1));

    assign stall_o  = !w_hit;
    assign instr_if = w_hit ? r_data[w_idx][w_off] : c_NOP;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;

    // Control state: FSM, valid bits, beat counter and request outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_state    <= S_REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {pc_if[31:2+c_OFF_W], {(2+c_OFF_W){1'b0}}};
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_state   <= S_FILL;
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                    end
                end
                S_FILL: begin
                    if (mem_rvalid) begin
                        r_cnt <= r_cnt + c_OFF_W'(1);
                        if (w_last_beat) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase

            // A flush seen during a refill suppresses the valid set at its end.
            if (w_last_beat) begin
                r_flush_pend <= 1'b0;
                if (!r_flush_pend && !flush_i) begin
                    r_valid[w_fill_idx] <= 1'b1;
                end
            end else if (flush_i && (r_state != S_IDLE)) begin
                r_flush_pend <= 1'b1;
            end

            if (flush_i) begin
                r_valid <= '0;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits alone gate visibility.
    always_ff @(posedge clk) begin
        if (!reset && w_beat) begin
            r_data[w_fill_idx][r_cnt] <= mem_rdata;
            if (w_last_beat) begin
                r_tag[w_fill_idx] <= w_fill_tag;
            end
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] r_perf_hits;
    logic [31:0] r_perf_misses;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_hits   <= '0;
            r_perf_misses <= '0;
        end else begin
            if (w_hit && (r_perf_hits != 32'hFFFF_FFFF)) begin
                r_perf_hits <= r_perf_hits + 32'd1;
            end
            if (w_miss && (r_perf_misses != 32'hFFFF_FFFF)) begin
                r_perf_misses <= r_perf_misses + 32'd1;
            end
        end
    end

    assign perf_hits_o   = r_perf_hits;
    assign perf_misses_o = r_perf_misses;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_icache
// Brief    : Directed, scoreboard-based bench for icache (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache;

    localparam int c_WPL = 4;
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_if = '0;
    logic [31:0] instr_if;
    logic        stall_o;
    logic        flush_i = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hits_o;
    logic [31:0] perf_misses_o;
`endif

    int          checks = 0;
    int          errors = 0;
    int          last_wait = 0;
    logic [31:0] exp_q[$];

    icache #(.NUM_LINES(16), .WORDS_PER_LINE(c_WPL)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_if      (pc_if),
        .instr_if   (instr_if),
        .stall_o    (stall_o),
        .flush_i    (flush_i),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hits_o   (perf_hits_o),
        .perf_misses_o (perf_misses_o)
`endif
    );

    always #5 clk = ~clk;

    // Backing-memory contents: line 0 holds 0xA0..0xA3.
    function automatic logic [31:0] beat(input logic [31:0] line, input int k);
        return 32'hA0 + 32'(k) + (line << 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic wait_hit(input string name);
        logic [31:0] e;
        int n;
        n = 0;
        @(negedge clk);
        while (stall_o !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        chk({name, "_stall"}, 32'(stall_o), 32'd0);
        chk({name, "_noreq"}, 32'(mem_req), 32'd0);
        e = exp_q.pop_front();
        chk(name, instr_if, e);
    endtask

    task automatic do_fill(input logic [31:0] line, input int gnt_delay,
                           input int gap, input int flush_beat);
        @(negedge clk);
        chk("miss_stall", 32'(stall_o), 32'd1);
        chk("miss_nop", instr_if, c_NOP);
        @(posedge clk); #1;
        chk("req", 32'(mem_req), 32'd1);
        chk("req_addr", mem_addr, line);
        for (int i = 0; i < gnt_delay; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_0000 + 32'(i);
            @(posedge clk); #1;
            chk("req_hold", 32'(mem_req), 32'd1);
            chk("addr_hold", mem_addr, line);
            chk("stall_req", 32'(stall_o), 32'd1);
        end
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("req_drop", 32'(mem_req), 32'd0);
        for (int k = 0; k < c_WPL; k++) begin
            if (k > 0) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                    chk("stall_gap", 32'(stall_o), 32'd1);
                end
            end
            mem_rvalid = 1'b1;
            mem_rdata  = beat(line, k);
            flush_i    = (k == flush_beat);
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            flush_i    = 1'b0;
            if (k < c_WPL - 1) begin
                chk("stall_fill", 32'(stall_o), 32'd1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and cold start
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        reset = 1'b0;
        do_fill(32'h0, 0, 0, -1);
        exp_q.push_back(32'hA0);
        wait_hit("cold_hit");
        chk("cold_latency", 32'(last_wait), 32'd0);

        // Same-line hits
        for (int w = 1; w < 4; w++) begin
            @(posedge clk); #1;
            pc_if = 32'(w * 4);
            exp_q.push_back(beat(32'h0, w));
            wait_hit("line_hit");
        end

        // Conflict eviction, then gapped refill of the evicted line
        @(posedge clk); #1;
        pc_if = 32'h100;
        do_fill(32'h100, 0, 0, -1);
        exp_q.push_back(beat(32'h100, 0));
        wait_hit("conflict_hit");
        @(posedge clk); #1;
        pc_if = 32'h0;
        do_fill(32'h0, 3, 2, -1);
        exp_q.push_back(beat(32'h0, 0));
        wait_hit("gap_hit0");
        for (int w = 1; w < 4; w++) begin
            @(posedge clk); #1;
            pc_if = 32'(w * 4);
            exp_q.push_back(beat(32'h0, w));
            wait_hit("gap_hitw");
        end

        // Flush during beat 2: refill completes but the line stays invalid
        @(posedge clk); #1;
        pc_if = 32'h40;
        do_fill(32'h40, 0, 0, 2);
        do_fill(32'h40, 0, 0, -1);
        exp_q.push_back(beat(32'h40, 0));
        wait_hit("post_flush_hit");

        // Flush in IDLE: the flush cycle still hits, the next cycle misses
        @(posedge clk); #1;
        flush_i = 1'b1;
        exp_q.push_back(beat(32'h40, 0));
        wait_hit("flush_cycle");
        @(posedge clk); #1;
        flush_i = 1'b0;
        do_fill(32'h40, 1, 1, -1);
        exp_q.push_back(beat(32'h40, 0));
        wait_hit("refill_hit");

        // Reset after two beats, stray beats afterwards
        @(posedge clk); #1;
        pc_if = 32'h80;
        @(negedge clk);
        chk("rmiss_stall", 32'(stall_o), 32'd1);
        @(posedge clk); #1;
        chk("rmiss_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = beat(32'h80, k);
            @(posedge clk); #1;
        end
        reset      = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_addr", mem_addr, 32'h0);
        do_fill(32'h80, 2, 0, -1);
        exp_q.push_back(beat(32'h80, 0));
        wait_hit("rst_refill_hit");
        @(posedge clk); #1;
        pc_if = 32'h88;
        exp_q.push_back(beat(32'h80, 2));
        wait_hit("rst_refill_w2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache. It is the responder on the fetch stage's instruction port: it takes the fetch PC and returns the instruction word in the same cycle on a hit. On a miss it stalls fetch and refills one line from backing memory through a request/grant + beat-valid interface.

## Interface
Parameters:
- NUM_LINES, 16: number of cache lines; power of 2, at least 2.
- WORDS_PER_LINE, 4: 32-bit words per line; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_if  in  32  fetch address from the fetch stage; bits [1:0] ignored.
- instr_if  out  32  instruction word to the fetch stage.
- stall_o  out  1  high while pc_if cannot be served; fetch holds the PC and the IF/ID register.
- flush_i  in  1  invalidate all lines (fence.i).
- mem_req  out  1  line refill request.
- mem_addr  out  32  line-aligned refill address.
- mem_gnt  in  1  refill request accepted.
- mem_rdata  in  32  refill data beat.
- mem_rvalid  in  1  mem_rdata is valid this cycle.

## Operation
- Address split: word offset = pc_if[1+log2(WORDS_PER_LINE):2]; index = the next log2(NUM_LINES) bits; tag = the remaining upper bits.
- Storage: a valid bit, a tag and WORDS_PER_LINE data words per line, held in flops. Lookup is combinational.
- Hit: the line is valid and the tags match while the FSM is in IDLE. Then instr_if = the selected word and stall_o = 0.
- Miss (including any cycle when the FSM is not in IDLE): instr_if = 32'h00000013 (NOP) and stall_o = 1.
- FSM states: IDLE, REQ, FILL.
  - IDLE -> REQ on a miss. The miss line address (pc_if with the offset bits zeroed) is latched.
  - REQ: mem_req = 1 and mem_addr = latched address. Both are held until mem_gnt; then go to FILL.
  - FILL: a beat counter starts at 0. Each mem_rvalid writes mem_rdata to word[counter] of the indexed line, then the counter increments.
  - On the beat with counter = WORDS_PER_LINE-1: write the tag, set valid, go to IDLE.
- Beats arrive in ascending word order and may have arbitrary gaps. mem_rvalid is ignored outside FILL. mem_gnt is ignored outside REQ.
- The fetch stage holds pc_if stable while stall_o is 1. The cache uses only the latched address during refill.
- Flush:
  - In IDLE: clears every valid bit at the next edge. A lookup in the flush cycle still uses the old valid bits.
  - In REQ/FILL: the refill runs to completion, but the line is not marked valid and all valid bits are cleared. The next lookup misses again.
- Reset (including mid-refill): FSM -> IDLE, all valid bits cleared, beat counter 0, mem_req 0. Beats arriving after reset are ignored. Tag and data contents are not reset.

## Timing
- Reset values: mem_req = 0 and mem_addr = 0. stall_o = 1 and instr_if = NOP for a first lookup, because all lines are invalid.
- Hit latency: 0 cycles (combinational from pc_if). Fetch registers instr_if at the next edge.
- Miss timeline with a zero-wait memory (gnt in the first REQ cycle, back-to-back beats starting the cycle after gnt):
  - miss detected at cycle T;
  - REQ at T+1;
  - FILL at T+2..T+1+WORDS_PER_LINE;
  - hit at T+2+WORDS_PER_LINE.
  - That is 6 stall cycles with default parameters.
- Outputs mem_req and mem_addr come directly from flops (registered). stall_o and instr_if are combinational.
- Each line is fully written before its valid bit is set. A partially filled line is never visible.

## Configuration
- ICACHE_PERF_EN defined: adds two 32-bit saturating counters, perf_hits_o and perf_misses_o (outputs), both reset to 0.
  - perf_hits_o increments on each IDLE cycle with a hit.
  - perf_misses_o increments on each IDLE->REQ transition.
- ICACHE_PERF_EN undefined: no counters and no ports. Behaviour is otherwise identical.

## Test plan
- Cold start: after reset, pc_if = 0x00000000 -> stall_o = 1, instr_if = 0x00000013, mem_req rises the next cycle with mem_addr = 0x00000000. Supply 4 beats 0xA0..0xA3 -> one cycle after the last beat, stall_o = 0 and instr_if = 0xA0.
- Same-line hits: after the fill above, pc_if = 0x4, 0x8, 0xC -> instr_if = 0xA1, 0xA2, 0xA3, each with stall_o = 0 and no mem_req.
- Conflict eviction: fill 0x000, then access 0x100 (same index, different tag) -> miss with mem_addr = 0x100; afterwards 0x000 misses again.
- Gapped refill: hold mem_gnt low 3 cycles and insert 2 idle cycles between beats -> mem_req and mem_addr are stable until gnt, all words land correctly, stall_o stays 1 throughout.
- Flush mid-FILL: assert flush_i during beat 2 -> refill completes, then the same pc_if misses and re-requests mem_addr.
- Reset mid-FILL after 2 beats, with stray mem_rvalid pulses afterwards -> mem_req = 0, the line stays invalid, and the next access to that line issues a fresh request.
